// File: rtl/wb_unit_if.sv
// ============================================================================
//  Module      : wb_unit_if
//  Description : Bundle for the writeback stage: execute-side handshake,
//                data-memory response channel, register-file write port and
//                hazard/retire status.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_unit_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    // execute -> writeback
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_rd;
    logic               in_wen;
    logic [XLEN-1:0]    in_result;
    logic               in_load;
    logic [2:0]         in_funct3;
    // data-memory response
    logic               mem_rvalid;
    logic [XLEN-1:0]    mem_rdata;
    logic               mem_rready;
    // register-file write port
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    rd_value;
    logic               R_wen;
    // status
    logic               busy;
    logic [RADDR_W-1:0] busy_rd;
    logic [63:0]        instret;

    // Environment side (execute stage, memory, register file)
    modport master (
        output in_valid, in_rd, in_wen, in_result, in_load, in_funct3,
        output mem_rvalid, mem_rdata,
        input  in_ready, mem_rready, rd, rd_value, R_wen, busy, busy_rd, instret
    );

    // Writeback unit side
    modport slave (
        input  in_valid, in_rd, in_wen, in_result, in_load, in_funct3,
        input  mem_rvalid, mem_rdata,
        output in_ready, mem_rready, rd, rd_value, R_wen, busy, busy_rd, instret
    );
endinterface

`default_nettype wire

// File: rtl/wb_unit.sv
// ============================================================================
//  Module      : wb_unit
//  Description : RV32 writeback stage. Registers non-load results, waits for
//                load data, extracts/extends byte/halfword/word and drives
//                the register-file write port one cycle later.
//                Optional macro WB_INSTRET_EN builds the 64-bit retired-
//                instruction counter; otherwise instret is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  wire         clk,
    input  wire         rst,     // asynchronous, active-low
    wb_unit_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [RADDR_W-1:0] r_ld_rd;
    logic               r_ld_wen;
    logic [2:0]         r_ld_funct3;
    logic [1:0]         r_ld_addr_lo;

    logic [RADDR_W-1:0] r_rd;
    logic [XLEN-1:0]    r_rd_value;
    logic               r_wen;

    logic               w_accept;
    logic               w_accept_alu;
    logic               w_accept_load;
    logic               w_load_done;
    logic               w_retire;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [XLEN-1:0]    w_ext;

    assign w_accept      = bus.in_valid && (r_state == IDLE);
    assign w_accept_alu  = w_accept && !bus.in_load;
    assign w_accept_load = w_accept &&  bus.in_load;
    assign w_load_done   = (r_state == WAIT_MEM) && bus.mem_rvalid;
    assign w_retire      = w_accept_alu || w_load_done;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state   = r_state;
        bus.in_ready   = 1'b0;
        bus.mem_rready = 1'b0;
        bus.busy       = 1'b0;
        bus.busy_rd    = '0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (w_accept_load) w_next_state = WAIT_MEM;
            end
            WAIT_MEM: begin
                bus.mem_rready = 1'b1;
                bus.busy       = 1'b1;
                bus.busy_rd    = r_ld_rd;
                if (bus.mem_rvalid) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Capture the load's destination and width info while waiting on memory
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_rd      <= '0;
            r_ld_wen     <= 1'b0;
            r_ld_funct3  <= 3'b000;
            r_ld_addr_lo <= 2'b00;
        end else if (w_accept_load) begin
            r_ld_rd      <= bus.in_rd;
            r_ld_wen     <= bus.in_wen;
            r_ld_funct3  <= bus.in_funct3;
            r_ld_addr_lo <= bus.in_result[1:0];
        end
    end

    // Select the addressed byte/halfword and extend to XLEN
    always_comb begin
        w_byte = 8'h00;
        case (r_ld_addr_lo)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_ld_addr_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_ld_funct3)
            3'b000:  w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_ext = bus.mem_rdata;   // LW and reserved codes
        endcase
    end

    // Register-file write port; x0 is never written but address/data still move
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd       <= '0;
            r_rd_value <= '0;
            r_wen      <= 1'b0;
        end else if (w_accept_alu) begin
            r_rd       <= bus.in_rd;
            r_rd_value <= bus.in_result;
            r_wen      <= bus.in_wen && (bus.in_rd != '0);
        end else if (w_load_done) begin
            r_rd       <= r_ld_rd;
            r_rd_value <= w_ext;
            r_wen      <= r_ld_wen && (r_ld_rd != '0);
        end else begin
            r_wen      <= 1'b0;
        end
    end

    assign bus.rd       = r_rd;
    assign bus.rd_value = r_rd_value;
    assign bus.R_wen    = r_wen;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    // Retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_instret <= 64'd0;
        else if (w_retire) r_instret <= r_instret + 64'd1;
    end

    assign bus.instret = r_instret;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign bus.instret     = 64'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_unit.sv
// ============================================================================
//  Module      : tb_wb_unit
//  Description : Directed self-checking bench for wb_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_unit;

`ifdef WB_INSTRET_EN
    localparam bit C_IR_ON = 1'b1;
`else
    localparam bit C_IR_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [63:0] exp_ir;
    logic [63:0] ir_count;

    wb_unit_if #(.XLEN(32), .RADDR_W(5)) bus ();

    wb_unit #(.XLEN(32), .RADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_rd      = 5'd0;
        bus.in_wen     = 1'b0;
        bus.in_result  = 32'h0;
        bus.in_load    = 1'b0;
        bus.in_funct3  = 3'b000;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.rd, bus.rd_value, bus.R_wen, bus.busy, bus.busy_rd, bus.mem_rready} !== 45'd0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%0d val=%h wen=%b busy=%b busy_rd=%0d mem_rready=%b, required all 0",
                     bus.rd, bus.rd_value, bus.R_wen, bus.busy, bus.busy_rd, bus.mem_rready);
        end
        checks++;
        if (bus.instret !== 64'd0) begin
            failures++;
            $display("FAIL reset_instret: got %0d required 0", bus.instret);
        end
        step();
        rst = 1'b1;
        ir_count = 64'd0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mem_rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b mem_rready=%b, required 1/0", bus.in_ready, bus.mem_rready);
        end
    endtask

    task automatic test_nonload_stream();
        bus.in_valid = 1'b1; bus.in_wen = 1'b1; bus.in_load = 1'b0;
        bus.in_rd = 5'd5; bus.in_result = 32'h0000_1234;
        step();
        ir_count++;
        checks++;
        if (bus.R_wen !== 1'b1 || bus.rd !== 5'd5 || bus.rd_value !== 32'h0000_1234) begin
            failures++;
            $display("FAIL alu_first: wen=%b rd=%0d val=%h required 1/5/00001234", bus.R_wen, bus.rd, bus.rd_value);
        end
        bus.in_rd = 5'd6; bus.in_result = 32'h0000_ABCD;
        step();
        ir_count++;
        checks++;
        if (bus.R_wen !== 1'b1 || bus.rd !== 5'd6 || bus.rd_value !== 32'h0000_ABCD) begin
            failures++;
            $display("FAIL alu_second: wen=%b rd=%0d val=%h required 1/6/0000abcd", bus.R_wen, bus.rd, bus.rd_value);
        end
        idle_inputs();
        step();
        checks++;
        if (bus.R_wen !== 1'b0) begin
            failures++;
            $display("FAIL alu_pulse_end: wen=%b required 0", bus.R_wen);
        end
        exp_ir = C_IR_ON ? 64'd2 : 64'd0;
        checks++;
        if (bus.instret !== exp_ir) begin
            failures++;
            $display("FAIL instret_after_stream: got %0d required %0d", bus.instret, exp_ir);
        end
    endtask

    task automatic test_rd_zero();
        bus.in_valid = 1'b1; bus.in_wen = 1'b1; bus.in_load = 1'b0;
        bus.in_rd = 5'd0; bus.in_result = 32'hFFFF_FFFF;
        step();
        ir_count++;
        idle_inputs();
        checks++;
        if (bus.R_wen !== 1'b0 || bus.rd !== 5'd0 || bus.rd_value !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL rd_zero: wen=%b rd=%0d val=%h required 0/0/ffffffff", bus.R_wen, bus.rd, bus.rd_value);
        end
        // in_wen=0 to a real register must also stay silent
        bus.in_valid = 1'b1; bus.in_wen = 1'b0; bus.in_rd = 5'd9; bus.in_result = 32'h55;
        step();
        ir_count++;
        idle_inputs();
        checks++;
        if (bus.R_wen !== 1'b0 || bus.rd !== 5'd9) begin
            failures++;
            $display("FAIL wen_low: wen=%b rd=%0d required 0/9", bus.R_wen, bus.rd);
        end
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [4:0] rdn,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp_val);
        bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_wen = 1'b1;
        bus.in_rd = rdn; bus.in_result = addr; bus.in_funct3 = f3;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.busy_rd !== rdn || bus.in_ready !== 1'b0 ||
                bus.mem_rready !== 1'b1 || bus.R_wen !== 1'b0) begin
                failures++;
                $display("FAIL %s_wait%0d: busy=%b busy_rd=%0d in_ready=%b mem_rready=%b wen=%b required 1/%0d/0/1/0",
                         name, i, bus.busy, bus.busy_rd, bus.in_ready, bus.mem_rready, bus.R_wen, rdn);
            end
            if (i < 2) step();
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
        step();
        ir_count++;
        idle_inputs();
        checks++;
        if (bus.R_wen !== 1'b1 || bus.rd !== rdn || bus.rd_value !== exp_val ||
            bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_data: wen=%b rd=%0d val=%h busy=%b in_ready=%b required 1/%0d/%h/0/1",
                     name, bus.R_wen, bus.rd, bus.rd_value, bus.busy, bus.in_ready, rdn, exp_val);
        end
    endtask

    task automatic test_loads();
        do_load("LB",   3'b000, 5'd7,  32'h0000_1002, 32'h0080_0000, 32'hFFFF_FF80);
        do_load("LBU",  3'b100, 5'd7,  32'h0000_1002, 32'h0080_0000, 32'h0000_0080);
        do_load("LB0",  3'b000, 5'd8,  32'h0000_2000, 32'h8001_1234, 32'h0000_0034);
        do_load("LB3",  3'b000, 5'd8,  32'h0000_2003, 32'h8001_1234, 32'hFFFF_FF80);
        do_load("LH",   3'b001, 5'd10, 32'h0000_3002, 32'h8001_1234, 32'hFFFF_8001);
        do_load("LHU",  3'b101, 5'd10, 32'h0000_3002, 32'h8001_1234, 32'h0000_8001);
        do_load("LH3",  3'b001, 5'd11, 32'h0000_3003, 32'h8001_1234, 32'hFFFF_8001);
        do_load("LH0",  3'b001, 5'd11, 32'h0000_3000, 32'h8001_9234, 32'hFFFF_9234);
        do_load("LW",   3'b010, 5'd12, 32'h0000_4002, 32'h8001_1234, 32'h8001_1234);
        do_load("RSV",  3'b111, 5'd13, 32'h0000_4001, 32'h8001_1234, 32'h8001_1234);
        exp_ir = C_IR_ON ? ir_count : 64'd0;
        checks++;
        if (bus.instret !== exp_ir) begin
            failures++;
            $display("FAIL instret_after_loads: got %0d required %0d", bus.instret, exp_ir);
        end
    endtask

    task automatic test_back_to_back();
        // load completes, next cycle a non-load is accepted immediately
        do_load("B2B", 3'b010, 5'd14, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        bus.in_valid = 1'b1; bus.in_load = 1'b0; bus.in_wen = 1'b1;
        bus.in_rd = 5'd15; bus.in_result = 32'h0BAD_BEEF;
        step();
        ir_count++;
        idle_inputs();
        checks++;
        if (bus.R_wen !== 1'b1 || bus.rd !== 5'd15 || bus.rd_value !== 32'h0BAD_BEEF) begin
            failures++;
            $display("FAIL b2b_alu: wen=%b rd=%0d val=%h required 1/15/0badbeef", bus.R_wen, bus.rd, bus.rd_value);
        end
    endtask

    task automatic test_idle_rvalid();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
        step();
        idle_inputs();
        checks++;
        if (bus.R_wen !== 1'b0 || bus.mem_rready !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_rvalid: wen=%b mem_rready=%b busy=%b required 0/0/0", bus.R_wen, bus.mem_rready, bus.busy);
        end
        exp_ir = C_IR_ON ? ir_count : 64'd0;
        checks++;
        if (bus.instret !== exp_ir) begin
            failures++;
            $display("FAIL instret_idle_rvalid: got %0d required %0d", bus.instret, exp_ir);
        end
    endtask

    task automatic test_reset_mid_load();
        bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_wen = 1'b1;
        bus.in_rd = 5'd20; bus.in_result = 32'h0; bus.in_funct3 = 3'b010;
        step();
        idle_inputs();
        checks++;
        if (bus.busy !== 1'b1 || bus.busy_rd !== 5'd20) begin
            failures++;
            $display("FAIL midload_busy: busy=%b busy_rd=%0d required 1/20", bus.busy, bus.busy_rd);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_rready !== 1'b0 || bus.busy !== 1'b0 || bus.busy_rd !== 5'd0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midload_async: mem_rready=%b busy=%b busy_rd=%0d in_ready=%b required 0/0/0/1",
                     bus.mem_rready, bus.busy, bus.busy_rd, bus.in_ready);
        end
        step();
        rst = 1'b1;
        ir_count = 64'd0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        checks++;
        if (bus.R_wen !== 1'b0 || bus.busy !== 1'b0 || bus.rd_value !== 32'h0) begin
            failures++;
            $display("FAIL midload_drop: wen=%b busy=%b val=%h required 0/0/00000000", bus.R_wen, bus.busy, bus.rd_value);
        end
        checks++;
        if (bus.instret !== 64'd0) begin
            failures++;
            $display("FAIL midload_instret: got %0d required 0", bus.instret);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ir_count = 64'd0;
        exp_ir   = 64'd0;
        rst      = 1'b1;
        idle_inputs();
        step();
        test_reset();
        test_nonload_stream();
        test_rd_zero();
        test_loads();
        test_back_to_back();
        test_idle_rvalid();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
